// File: rtl/pc_pkg.sv
// pc_pkg: branch funct3 codes, BTB entry layout and saturating 2-bit counter helpers
package pc_pkg;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  // Tag and target fields are sized for the widest supported PC; narrower
  // configurations zero-extend into them.
  localparam int PC_W = 32;
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/btb.sv
// btb: direct-mapped branch target buffer with 2-bit taken counters
//  clk, rst_n        clock, async active-low reset (clears all entries)
//  lookup_pc         fetch PC to look up
//  pred_taken        entry hit and counter says taken
//  pred_target       stored target of the looked-up entry
//  upd_en            EX holds a resolved branch/jump
//  upd_pc            PC of that branch/jump
//  upd_taken         it was taken
//  upd_target        its resolved target
module btb
  import pc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_en,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);
  localparam int IDX = $clog2(ENTRIES);
  btb_entry_t mem [ENTRIES];
  btb_entry_t rd, cur, nxt;
  logic [IDX-1:0] ri, ui;
  logic [PC_W-1:0] rtag, utag;
  logic uhit;
  assign ri = lookup_pc[IDX+1:2];
  assign ui = upd_pc[IDX+1:2];
  assign rtag = PC_W'(lookup_pc[WIDTH-1:IDX+2]);
  assign utag = PC_W'(upd_pc[WIDTH-1:IDX+2]);
  // Lookup sees the array before this cycle's update lands (no bypass).
  assign rd = mem[ri];
  assign pred_taken = rd.valid && rd.tag == rtag && rd.ctr[1];
  assign pred_target = rd.target[WIDTH-1:0];
  assign cur = mem[ui];
  assign uhit = cur.valid && cur.tag == utag;
  always_comb begin
    nxt = cur;
    nxt.valid = 1'b1;
    nxt.tag = utag;
    nxt.target = upd_taken ? PC_W'(upd_target) : cur.target;
    nxt.ctr = !uhit ? 2'b10 : upd_taken ? ctr_inc(cur.ctr) : ctr_dec(cur.ctr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    else if (upd_en && (uhit || upd_taken))
      mem[ui] <= nxt;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register, EX branch/jump resolution, redirect/flush and mispredict count
//  Inputs: clk, rst_n (async active-low), StallF, EX-stage branch info
//   (ValidE, BranchE, JumpE, JALRE, Funct3E, ZeroE, LtE, LtuE, PCE, PCTargetE,
//   ALUResultE, PredNextE).
//  Outputs: PCF, PCPlus4F, PredNextF, FlushD, FlushE, MispredictCnt.
//  Define BTB_PREDICT_EN to predict with a BTB; otherwise prediction is static not-taken.
module pc_redirect_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               BTB_ENTRIES = 16,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             ValidE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             JALRE,
  input  logic [2:0]       Funct3E,
  input  logic             ZeroE,
  input  logic             LtE,
  input  logic             LtuE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] PredNextE,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic [WIDTH-1:0] PredNextF,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] MispredictCnt
);
  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_btb
    $error("BTB_ENTRIES must be a power of 2 and >= 2");
  end
  logic cond, taken, mispred;
  logic [WIDTH-1:0] target, actual;
  always_comb
    cond = Funct3E == BR_BEQ  ? ZeroE :
           Funct3E == BR_BNE  ? !ZeroE :
           Funct3E == BR_BLT  ? LtE :
           Funct3E == BR_BGE  ? !LtE :
           Funct3E == BR_BLTU ? LtuE :
           Funct3E == BR_BGEU ? !LtuE : 1'b0;
  assign taken = JumpE || (BranchE && cond);
  assign target = (JumpE && JALRE) ? {ALUResultE[WIDTH-1:1], 1'b0} : PCTargetE;
  assign actual = taken ? target : PCE + WIDTH'(4);
  assign mispred = ValidE && actual != PredNextE;
  assign FlushD = mispred;
  assign FlushE = mispred;
  assign PCPlus4F = PCF + WIDTH'(4);
`ifdef BTB_PREDICT_EN
  logic btb_taken;
  logic [WIDTH-1:0] btb_target;
  btb #(.WIDTH(WIDTH), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk(clk),
    .rst_n(rst_n),
    .lookup_pc(PCF),
    .pred_taken(btb_taken),
    .pred_target(btb_target),
    .upd_en(ValidE && (BranchE || JumpE)),
    .upd_pc(PCE),
    .upd_taken(taken),
    .upd_target(target)
  );
  assign PredNextF = btb_taken ? btb_target : PCPlus4F;
`else
  assign PredNextF = PCPlus4F;
`endif
  // A redirect must land even while the hazard unit stalls fetch.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      PCF <= RESET_PC;
      MispredictCnt <= '0;
    end else begin
      PCF <= mispred ? actual : StallF ? PCF : PredNextF;
      MispredictCnt <= (mispred && !(&MispredictCnt)) ? MispredictCnt + CNT_W'(1) : MispredictCnt;
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed checks of PC sequencing, branch resolution, redirect, flush and counter saturation
module tb_pc_redirect_unit;
  import pc_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, StallF = 1'b0, ValidE = 1'b0, BranchE = 1'b0;
  logic JumpE = 1'b0, JALRE = 1'b0, ZeroE = 1'b0, LtE = 1'b0, LtuE = 1'b0;
  logic [2:0] Funct3E = '0;
  logic [31:0] PCE = '0, PCTargetE = '0, ALUResultE = '0, PredNextE = '0;
  logic [31:0] PCF, PCPlus4F, PredNextF;
  logic FlushD, FlushE;
  logic [1:0] MispredictCnt;
  int tests = 0, fails = 0;
  pc_redirect_unit #(.WIDTH(32), .RESET_PC(32'h0), .BTB_ENTRIES(16), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .ValidE(ValidE), .BranchE(BranchE),
    .JumpE(JumpE), .JALRE(JALRE), .Funct3E(Funct3E), .ZeroE(ZeroE), .LtE(LtE),
    .LtuE(LtuE), .PCE(PCE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
    .PredNextE(PredNextE), .PCF(PCF), .PCPlus4F(PCPlus4F), .PredNextF(PredNextF),
    .FlushD(FlushD), .FlushE(FlushE), .MispredictCnt(MispredictCnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    ValidE = 0; BranchE = 0; JumpE = 0; JALRE = 0; StallF = 0;
  endtask
  task automatic ex(input logic br, input logic jmp, input logic jalr, input logic [2:0] f3,
                    input logic z, input logic lt, input logic ltu, input logic [31:0] pc,
                    input logic [31:0] tgt, input logic [31:0] alu, input logic [31:0] pred);
    ValidE = 1; BranchE = br; JumpE = jmp; JALRE = jalr; Funct3E = f3; StallF = 0;
    ZeroE = z; LtE = lt; LtuE = ltu; PCE = pc; PCTargetE = tgt; ALUResultE = alu; PredNextE = pred;
    #1;
  endtask
  initial begin
    idle;
    repeat (3) tick;
    check("rst_pcf", PCF, 32'h0);
    check("rst_cnt", 32'(MispredictCnt), 32'd0);
    check("rst_flushd", 32'(FlushD), 32'd0);
    check("rst_plus4", PCPlus4F, 32'h4);
    check("rst_pred", PredNextF, 32'h4);
    rst_n = 1;
    tick;
    check("seq_pcf1", PCF, 32'h4);
    tick;
    check("seq_pcf2", PCF, 32'h8);
    ex(1, 0, 0, BR_BEQ, 0, 0, 0, 32'h20, 32'h100, 32'h0, 32'h24);
    check("beq_nt_flush", 32'(FlushD), 32'd0);
    tick;
    check("beq_nt_pcf", PCF, 32'hC);
    ex(1, 0, 0, BR_BEQ, 1, 0, 0, 32'h24, 32'h200, 32'h0, 32'h200);
    check("beq_t_pred_ok", 32'(FlushE), 32'd0);
    tick;
    check("beq_t_pcf", PCF, 32'h10);
    ex(1, 0, 0, 3'b010, 1, 1, 1, 32'h28, 32'h300, 32'h0, 32'h2C);
    check("f3_010_flush", 32'(FlushD), 32'd0);
    tick;
    check("f3_010_pcf", PCF, 32'h14);
    ex(1, 0, 0, BR_BLTU, 0, 0, 1, 32'h40, 32'h80, 32'h0, 32'h44);
    check("bltu_flushd", 32'(FlushD), 32'd1);
    check("bltu_flushe", 32'(FlushE), 32'd1);
    tick;
    check("bltu_pcf", PCF, 32'h80);
    check("bltu_cnt", 32'(MispredictCnt), 32'd1);
    ex(0, 1, 1, BR_BEQ, 0, 0, 0, 32'h80, 32'h999, 32'h123, 32'h84);
    StallF = 1;
    #1;
    check("jalr_flush", 32'(FlushD), 32'd1);
    tick;
    check("jalr_pcf", PCF, 32'h122);
    check("jalr_cnt", 32'(MispredictCnt), 32'd2);
    idle;
    StallF = 1;
    #1;
    check("stall_flush", 32'(FlushD), 32'd0);
    tick;
    check("stall_pcf", PCF, 32'h122);
    ex(1, 0, 0, BR_BLTU, 0, 0, 1, 32'h40, 32'h80, 32'h0, 32'h44);
    ValidE = 0;
    #1;
    check("bubble_flush", 32'(FlushE), 32'd0);
    tick;
    check("bubble_pcf", PCF, 32'h126);
    check("bubble_cnt", 32'(MispredictCnt), 32'd2);
    ex(1, 0, 0, BR_BGE, 0, 0, 1, 32'h2C, 32'h60, 32'h0, 32'h30);
    check("bge_flush", 32'(FlushD), 32'd1);
    tick;
    check("bge_pcf", PCF, 32'h60);
    check("bge_cnt", 32'(MispredictCnt), 32'd3);
    ex(1, 0, 0, BR_BNE, 0, 0, 0, 32'h60, 32'h10, 32'h0, 32'h64);
    tick;
    check("bne_pcf", PCF, 32'h10);
    check("sat_cnt1", 32'(MispredictCnt), 32'd3);
    ex(0, 1, 0, BR_BEQ, 0, 0, 0, 32'h10, 32'h400, 32'h777, 32'h14);
    check("jal_flush", 32'(FlushD), 32'd1);
    tick;
    check("jal_pcf", PCF, 32'h400);
    check("sat_cnt2", 32'(MispredictCnt), 32'd3);
    ex(1, 0, 0, BR_BLT, 0, 0, 1, 32'h400, 32'h500, 32'h0, 32'h404);
    check("blt_nt_flush", 32'(FlushD), 32'd0);
    ex(1, 0, 0, BR_BGEU, 1, 1, 1, 32'h404, 32'h500, 32'h0, 32'h408);
    check("bgeu_nt_flush", 32'(FlushD), 32'd0);
    ex(1, 0, 0, BR_BLTU, 0, 0, 1, 32'h40, 32'h80, 32'h0, 32'h44);
    rst_n = 0;
    #1;
    check("midrst_pcf", PCF, 32'h0);
    check("midrst_cnt", 32'(MispredictCnt), 32'd0);
    tick;
    check("midrst_hold", PCF, 32'h0);
    idle;
    tick;
    rst_n = 1;
`ifdef BTB_PREDICT_EN
    repeat (4) tick;
    check("btb_miss_pred", PredNextF, 32'h14);
    ex(1, 0, 0, BR_BEQ, 1, 0, 0, 32'h10, 32'h0, 32'h0, 32'h14);
    check("btb_p1_flush", 32'(FlushD), 32'd1);
    tick;
    check("btb_p1_pcf", PCF, 32'h0);
    check("btb_p1_cnt", 32'(MispredictCnt), 32'd1);
    for (int p = 0; p < 2; p++) begin
      idle;
      repeat (4) tick;
      check("btb_hit_pred", PredNextF, 32'h0);
      ex(1, 0, 0, BR_BEQ, 1, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0);
      check("btb_hit_flush", 32'(FlushD), 32'd0);
      tick;
      check("btb_hit_pcf", PCF, 32'h0);
    end
    idle;
    repeat (4) tick;
    ex(1, 0, 0, BR_BEQ, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0);
    check("btb_exit_flush", 32'(FlushD), 32'd1);
    tick;
    check("btb_exit_pcf", PCF, 32'h14);
    check("btb_exit_cnt", 32'(MispredictCnt), 32'd2);
    ex(0, 1, 0, BR_BEQ, 0, 0, 0, 32'h14, 32'h10, 32'h0, 32'h18);
    tick;
    idle;
    #1;
    check("btb_ctr2_pred", PredNextF, 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
